// File: rtl/host_arb_pkg.sv
// Shared types and constants for the host memory arbiter: FSM states, port ids, counter sizing.
package host_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic ID_SPI  = 1'b0;
  localparam logic ID_UART = 1'b1;

  // Width of the read-latency down-counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/host_arb_rr_pick.sv
// Two-way request picker: round-robin against the last winner, or fixed priority to port 0.
module host_arb_rr_pick
  import host_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr,
  output logic       win_c,
  output logic       any_c
);

  always_comb begin
    any_c = |req;
    win_c = ID_SPI;
    if (req == 2'b11) begin
      win_c = rr ? ~last : ID_SPI;
    end else if (req[1]) begin
      win_c = ID_UART;
    end
  end

endmodule

// File: rtl/host_mem_arbiter.sv
// Shares the single host memory port between the SPI bridge (port 0) and the UART loader (port 1),
// one transaction at a time, returning read data to the winning port.
module host_mem_arbiter
  import host_arb_pkg::*;
#(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned RR     = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          S0_REQ,
  input  logic          S0_WE,
  input  logic [AW-1:0] S0_ADDR,
  input  logic [DW-1:0] S0_WD,
  output logic          S0_GNT,
  output logic          S0_RVALID,
  output logic [DW-1:0] S0_RD,
  input  logic          S1_REQ,
  input  logic          S1_WE,
  input  logic [AW-1:0] S1_ADDR,
  input  logic [DW-1:0] S1_WD,
  output logic          S1_GNT,
  output logic          S1_RVALID,
  output logic [DW-1:0] S1_RD,
  output logic          M_EN,
  output logic          M_WE,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WD,
  input  logic [DW-1:0] M_RD,
  output logic          BUSY
);

  localparam int unsigned CW = cnt_width(RD_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);

  if (RD_LAT == 0) begin : g_bad_rd_lat
    $error("host_mem_arbiter: RD_LAT must be at least 1");
  end

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          s0_gnt_d, s1_gnt_d, s0_rvalid_d, s1_rvalid_d;
  logic [DW-1:0] s0_rd_d, s1_rd_d;
  logic          m_en_d, m_we_d, busy_d;
  logic [AW-1:0] m_addr_d;
  logic [DW-1:0] m_wd_d;

  logic          pick_win_c, pick_any_c;

  host_arb_rr_pick u_pick (
    .req   ({S1_REQ, S0_REQ}),
    .last  (last_q),
    .rr    (RR != 0),
    .win_c (pick_win_c),
    .any_c (pick_any_c)
  );

  // Next state and next values of every registered output; M_ADDR/M_WD double as the request latch.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    s0_gnt_d    = 1'b0;
    s1_gnt_d    = 1'b0;
    s0_rvalid_d = 1'b0;
    s1_rvalid_d = 1'b0;
    s0_rd_d     = S0_RD;
    s1_rd_d     = S1_RD;
    m_en_d      = 1'b0;
    m_we_d      = 1'b0;
    m_addr_d    = M_ADDR;
    m_wd_d      = M_WD;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any_c) begin
          state_d  = ST_ISSUE;
          win_d    = pick_win_c;
          m_en_d   = 1'b1;
          m_we_d   = (pick_win_c == ID_UART) ? S1_WE   : S0_WE;
          m_addr_d = (pick_win_c == ID_UART) ? S1_ADDR : S0_ADDR;
          m_wd_d   = (pick_win_c == ID_UART) ? S1_WD   : S0_WD;
          s0_gnt_d = (pick_win_c == ID_SPI);
          s1_gnt_d = (pick_win_c == ID_UART);
        end
      end
      ST_ISSUE: begin
        last_d = win_q;
        if (M_WE) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          s0_rvalid_d = (win_q == ID_SPI);
          s1_rvalid_d = (win_q == ID_UART);
          if (win_q == ID_UART) s1_rd_d = M_RD;
          else                  s0_rd_d = M_RD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      win_q     <= ID_SPI;
      cnt_q     <= '0;
      S0_GNT    <= 1'b0;
      S1_GNT    <= 1'b0;
      S0_RVALID <= 1'b0;
      S1_RVALID <= 1'b0;
      S0_RD     <= '0;
      S1_RD     <= '0;
      M_EN      <= 1'b0;
      M_WE      <= 1'b0;
      M_ADDR    <= '0;
      M_WD      <= '0;
      BUSY      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      S0_GNT    <= s0_gnt_d;
      S1_GNT    <= s1_gnt_d;
      S0_RVALID <= s0_rvalid_d;
      S1_RVALID <= s1_rvalid_d;
      S0_RD     <= s0_rd_d;
      S1_RD     <= s1_rd_d;
      M_EN      <= m_en_d;
      M_WE      <= m_we_d;
      M_ADDR    <= m_addr_d;
      M_WD      <= m_wd_d;
      BUSY      <= busy_d;
    end
  end

endmodule
